// File: rtl/mm2s_pixel_unpacker.sv
// Unpacks the 64-bit mm2s word stream into 24-bit RGB pixels with SOF/EOL markers and a frame-done pulse.
// A word accepted into an empty buffer gives a pixel next cycle; pix_ready stalls feed back through the buffer level to mm2s_ready.
module mm2s_pixel_unpacker #(
    parameter int H_RES = 1280,
    parameter int V_RES = 720,
    parameter int X_W   = 11,
    parameter int Y_W   = 10
) (
    input  logic        m_axi_acp_aclk,
    input  logic        axi_resetn,
    input  logic        frame_start,
    input  logic [63:0] mm2s_data,
    input  logic        mm2s_valid,
    output logic        mm2s_ready,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic [4:0]  byte_level
);
    logic [127:0]   pix_buf;
    logic [127:0]   buf_nxt;
    logic [4:0]     level_nxt;
    logic [4:0]     wr_ofs;
    logic [X_W-1:0] x_q;
    logic [Y_W-1:0] y_q;
    logic           run_q;
    logic           in_fire;
    logic           out_fire;
    logic           last_x;
    logic           last_y;

    // run_q keeps mm2s_ready low until the first clock after reset release
    assign mm2s_ready = run_q & (byte_level <= 5'd8);
    assign pix_valid  = (byte_level >= 5'd3);
    assign pix_data   = pix_buf[23:0];
    assign last_x     = (x_q == X_W'(H_RES - 1));
    assign last_y     = (y_q == Y_W'(V_RES - 1));
    assign pix_sof    = pix_valid & (x_q == '0) & (y_q == '0);
    assign pix_eol    = pix_valid & last_x;
    assign in_fire    = mm2s_valid & mm2s_ready & ~frame_start;
    assign out_fire   = pix_valid & pix_ready & ~frame_start;

    // Bytes at or above byte_level are kept zero, so a new word can simply be OR-ed in.
    always_comb begin
        buf_nxt   = pix_buf;
        level_nxt = byte_level;
        wr_ofs    = byte_level;
        if (out_fire) begin
            buf_nxt   = pix_buf >> 24;
            level_nxt = byte_level - 5'd3;
            wr_ofs    = byte_level - 5'd3;
        end
        if (in_fire) begin
            buf_nxt   = buf_nxt | ({64'd0, mm2s_data} << {wr_ofs, 3'b000});
            level_nxt = level_nxt + 5'd8;
        end
    end

    always_ff @(posedge m_axi_acp_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            pix_buf    <= '0;
            byte_level <= '0;
            x_q        <= '0;
            y_q        <= '0;
            run_q      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            run_q      <= 1'b1;
            frame_done <= 1'b0;
            if (frame_start) begin
                pix_buf    <= '0;
                byte_level <= '0;
                x_q        <= '0;
                y_q        <= '0;
            end else begin
                pix_buf    <= buf_nxt;
                byte_level <= level_nxt;
                if (out_fire) begin
                    if (last_x) begin
                        x_q <= '0;
                        if (last_y) begin
                            y_q        <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            y_q <= y_q + Y_W'(1);
                        end
                    end else begin
                        x_q <= x_q + X_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mm2s_pixel_unpacker.sv
// Randomized bench for mm2s_pixel_unpacker against a byte-queue reference model (8x2 frame).
module tb_mm2s_pixel_unpacker;
    localparam int H  = 8;
    localparam int V  = 2;
    localparam int FP = H * V;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        frame_start = 1'b0;
    logic [63:0] mm2s_data = '0;
    logic        mm2s_valid = 1'b0;
    logic        mm2s_ready;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;
    logic [4:0]  byte_level;

    always #5 clk = ~clk;

    mm2s_pixel_unpacker #(.H_RES(H), .V_RES(V), .X_W(4), .Y_W(2)) dut (
        .m_axi_acp_aclk (clk),
        .axi_resetn     (rst_n),
        .frame_start    (frame_start),
        .mm2s_data      (mm2s_data),
        .mm2s_valid     (mm2s_valid),
        .mm2s_ready     (mm2s_ready),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .pix_sof        (pix_sof),
        .pix_eol        (pix_eol),
        .frame_done     (frame_done),
        .byte_level     (byte_level)
    );

    int errors = 0;
    int checks = 0;

    // reference model: bytes held, words waiting to be sent, pixel index in stream
    logic [7:0]  byte_q[$];
    logic [63:0] src_q[$];
    int          pix_idx = 0;
    bit          exp_done = 1'b0;
    bit          stalled = 1'b0;
    logic [23:0] held;
    int          cyc = 0;
    logic [23:0] got_q[$];
    int          acc_cyc[$];
    int          sof_pos[$];
    int          done_cyc[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic clear_logs();
        got_q.delete();
        acc_cyc.delete();
        sof_pos.delete();
        done_cyc.delete();
    endtask

    task automatic drive(input int vpct, input int rpct);
        mm2s_valid = (src_q.size() > 0) && ($urandom_range(99) < vpct);
        mm2s_data  = (src_q.size() > 0) ? src_q[0] : 64'd0;
        pix_ready  = ($urandom_range(99) < rpct);
    endtask

    // check outputs against the model at negedge, then apply the edge's effects to the model
    task automatic cycle();
        bit          inf;
        bit          outf;
        logic [23:0] ep;
        @(negedge clk);
        cyc++;
        check("byte_level", byte_level, byte_q.size());
        check("mm2s_ready", mm2s_ready, byte_q.size() <= 8);
        check("pix_valid", pix_valid, byte_q.size() >= 3);
        check("frame_done", frame_done, exp_done);
        if (frame_done) done_cyc.push_back(cyc);
        ep = '0;
        if (byte_q.size() >= 3) begin
            ep = {byte_q[2], byte_q[1], byte_q[0]};
            check("pix_data", pix_data, ep);
            check("pix_sof", pix_sof, (pix_idx % FP) == 0);
            check("pix_eol", pix_eol, (pix_idx % H) == H - 1);
        end else begin
            check("sof_idle", pix_sof, 0);
            check("eol_idle", pix_eol, 0);
        end
        if (stalled) check("stall_hold", pix_data, held);
        inf  = mm2s_valid && (byte_q.size() <= 8) && !frame_start;
        outf = (byte_q.size() >= 3) && pix_ready && !frame_start;
        stalled = (byte_q.size() >= 3) && !pix_ready && !frame_start;
        held = pix_data;
        if (outf) begin
            if (pix_sof) sof_pos.push_back(got_q.size());
            got_q.push_back(pix_data);
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        exp_done = 1'b0;
        if (frame_start) begin
            byte_q.delete();
            pix_idx = 0;
        end else begin
            if (outf) begin
                repeat (3) void'(byte_q.pop_front());
                if ((pix_idx % FP) == FP - 1) exp_done = 1'b1;
                pix_idx++;
            end
            if (inf) begin
                for (int b = 0; b < 8; b++) byte_q.push_back(mm2s_data[8*b +: 8]);
                void'(src_q.pop_front());
            end
        end
    endtask

    task automatic cycles(input int n, input int vpct, input int rpct);
        for (int i = 0; i < n; i++) begin
            drive(vpct, rpct);
            cycle();
        end
    endtask

    task automatic drain(input int vpct, input int rpct, input int budget);
        int n;
        n = 0;
        while ((src_q.size() > 0 || byte_q.size() > 0 || exp_done) && n < budget) begin
            drive(vpct, rpct);
            cycle();
            n++;
        end
        check("drain_budget", n < budget, 1);
        mm2s_valid = 1'b0;
    endtask

    task automatic push_inc(input int words, input int first);
        logic [63:0] w;
        for (int i = 0; i < words; i++) begin
            for (int b = 0; b < 8; b++) w[8*b +: 8] = 8'((first + i) * 8 + b);
            src_q.push_back(w);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ready"}, mm2s_ready, 0);
        check({tag, "_valid"}, pix_valid, 0);
        check({tag, "_sof"}, pix_sof, 0);
        check({tag, "_eol"}, pix_eol, 0);
        check({tag, "_done"}, frame_done, 0);
        check({tag, "_data"}, pix_data, 0);
        check({tag, "_level"}, byte_level, 0);
    endtask

    task automatic reset_model();
        byte_q.delete();
        src_q.delete();
        pix_idx  = 0;
        exp_done = 1'b0;
        stalled  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int done_before;

        // power-on reset
        #1 rst_n = 1'b0;
        #10;
        check_zero_outputs("por");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("por_ready_low", mm2s_ready, 0);

        // ordering and full frame at full rate
        clear_logs();
        push_inc(6, 0);
        drain(100, 100, 200);
        check("t2_pix0", got_q[0], 24'h020100);
        check("t2_pix1", got_q[1], 24'h050403);
        check("t2_pix2", got_q[2], 24'h080706);
        check("t2_pix7", got_q[7], 24'h171615);
        check("t3_npix", got_q.size(), 16);
        check("t3_span", acc_cyc[15] - acc_cyc[0], 15);
        check("t3_done_cnt", done_cyc.size(), 1);
        check("t3_done_lat", done_cyc[0] - acc_cyc[15], 1);
        check("t3_level_end", byte_level, 0);

        // back-to-back frames
        clear_logs();
        push_inc(12, 6);
        drain(100, 100, 200);
        check("t6_done_cnt", done_cyc.size(), 2);
        check("t6_done_gap", done_cyc[1] - done_cyc[0], 16);
        check("t6_sof_cnt", sof_pos.size(), 2);
        check("t6_sof0", sof_pos[0], 0);
        check("t6_sof1", sof_pos[1], 16);

        // random backpressure with random data
        clear_logs();
        for (int i = 0; i < 18; i++) src_q.push_back({$urandom, $urandom});
        drain(60, 50, 2000);
        check("t4_npix", got_q.size(), 48);
        check("t4_done_cnt", done_cyc.size(), 3);

        // frame_start abort after 5 pixels
        clear_logs();
        push_inc(6, 40);
        base = pix_idx;
        n = 0;
        while (pix_idx < base + 5 && n < 100) begin
            drive(100, 100);
            cycle();
            n++;
        end
        check("t5_reach5", pix_idx - base, 5);
        done_before = done_cyc.size();
        src_q.delete();
        frame_start = 1'b1;
        mm2s_valid  = 1'b0;
        pix_ready   = 1'b1;
        cycle();
        frame_start = 1'b0;
        check("t5_level_flush", byte_level, 0);
        check("t5_no_done", done_cyc.size(), done_before);
        clear_logs();
        push_inc(6, 60);
        drain(70, 70, 1000);
        check("t5_sof_first", sof_pos[0], 0);
        check("t5_done_cnt", done_cyc.size(), 1);

        // asynchronous reset mid-frame
        clear_logs();
        push_inc(4, 80);
        cycles(5, 100, 100);
        rst_n = 1'b0;
        #1;
        check_zero_outputs("t1_mid");
        reset_model();
        mm2s_valid = 1'b0;
        pix_ready  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t1_ready_low", mm2s_ready, 0);
        cycles(2, 0, 0);
        check("t1_ready_up", mm2s_ready, 1);
        check("t1_no_done", done_cyc.size(), 0);

        // clean frame after reset
        clear_logs();
        push_inc(6, 100);
        drain(80, 80, 1000);
        check("post_rst_done", done_cyc.size(), 1);
        check("post_rst_npix", got_q.size(), 16);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
